rgb_fader: RTL and testbench

Upstream duty-cycle source for the 16-bit PWM timer. Accepts target RGB duty values over a valid/ready handshake and either applies them at once or ramps the live duty outputs toward them. The ramp advances a fixed step once every `DIV` PWM periods. `duty_r/g/b` drive the timer's compare inputs; the timer's period pulse (`out`) returns as `period_tick`, so duty changes land on period boundaries.

---
 rtl/rgb_fader_pkg.sv | 13 +
 rtl/rgb_fader_fade_step.sv | 31 +++
 rtl/rgb_fader.sv | 135 +++++++++++++
 tb/tb_rgb_fader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fader_pkg.sv
// Shared definitions for the RGB duty fader: default duty width, FSM state
// encoding and the minimum ramp step.
package rgb_fader_pkg;

  localparam int W_DEF    = 16;
  localparam int STEP_MIN = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fader_state_e;

endpackage

// File: rtl/rgb_fader_fade_step.sv
// fade_step: one channel of the ramp. Purely combinational.
//   cur  - current duty
//   tgt  - target duty
//   step - largest allowed change (must be >= 1)
//   next - cur moved toward tgt by min(step, |tgt-cur|); never overshoots
module fade_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] next
);

  logic [W-1:0] diff;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if/else leaves it unassigned (which would infer a latch).
    diff = '0;
    next = cur;
    if (cur < tgt) begin
      diff = tgt - cur;
      next = cur + ((diff < step) ? diff : step);
    end else if (cur > tgt) begin
      diff = cur - tgt;
      next = cur - ((diff < step) ? diff : step);
    end
  end

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader: duty-cycle source for a 16-bit PWM timer.
// Accepts RGB targets over valid/ready and either jumps to them or ramps the
// live duties toward them, one clamped step every DIV timer periods.
//   clk, rst_n            - clock, asynchronous active-low reset
//   period_tick           - timer period pulse (level; rising edge counted once)
//   tgt_valid / tgt_ready - target handshake
//   tgt_r/g/b, fade_en    - target duties and jump(0)/ramp(1) select
//   duty_r/g/b            - registered live duties to the timer compares
//   busy                  - ramp in progress
//   done                  - one-cycle pulse when the duties reach the target
module rgb_fader
  import rgb_fader_pkg::*;
#(
  parameter int          W       = W_DEF,
  parameter int          DIV     = 4,
  parameter int unsigned STEP    = 16'h0040,
  parameter bit          PREEMPT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         period_tick,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt_r,
  input  logic [W-1:0] tgt_g,
  input  logic [W-1:0] tgt_b,
  input  logic         fade_en,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic         busy,
  output logic         done
);

  localparam int           DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0] STEP_EFF = (STEP == 0) ? W'(STEP_MIN) : W'(STEP);

  fader_state_e  state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q;
  logic          done_q, done_d;
  logic [W-1:0]  cur_q [3];
  logic [W-1:0]  cur_d [3];
  logic [W-1:0]  tgt_q [3];
  logic [W-1:0]  tgt_d [3];
  logic [W-1:0]  tgt_in [3];
  logic [W-1:0]  nxt [3];

  logic accept, tick_ev, at_target, step_done;

  assign tgt_in[0] = tgt_r;
  assign tgt_in[1] = tgt_g;
  assign tgt_in[2] = tgt_b;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    fade_step #(.W(W)) u_step (
      .cur  (cur_q[i]),
      .tgt  (tgt_q[i]),
      .step (STEP_EFF),
      .next (nxt[i])
    );
  end

  // Ready is forced low while reset is asserted, not just after it.
  assign tgt_ready = rst_n & ((state_q == ST_IDLE) | PREEMPT);
  assign accept    = tgt_valid & tgt_ready;
  assign tick_ev   = period_tick & ~tick_q;
  assign at_target = (tgt_in[0] == cur_q[0]) & (tgt_in[1] == cur_q[1]) &
                     (tgt_in[2] == cur_q[2]);
  assign step_done = (nxt[0] == tgt_q[0]) & (nxt[1] == tgt_q[1]) &
                     (nxt[2] == tgt_q[2]);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    done_d  = 1'b0;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    if (accept) begin
      // An accept always wins over a coinciding step.
      tgt_d = tgt_in;
      div_d = '0;
      if (!fade_en || at_target) begin
        cur_d   = tgt_in;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_FADE;
      end
    end else if (state_q == ST_FADE && tick_ev) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        cur_d = nxt;
        if (step_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the duty/target arrays are only three entries of flops, so they
    // are reset along with the rest; outputs must read 0 during reset.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= period_tick;
      done_q  <= done_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

  assign duty_r = cur_q[0];
  assign duty_g = cur_q[1];
  assign duty_b = cur_q[2];
  assign busy   = (state_q == ST_FADE);
  assign done   = done_q;

endmodule

// File: tb/tb_rgb_fader.sv
// Self-checking bench for rgb_fader (DIV=2, STEP=0x40, PREEMPT=1).
// A behavioural model tracks the duties as integers and counts tick events
// since the current fade began; every DIV-th event moves each channel toward
// its target by at most STEP.
module tb_rgb_fader;

  localparam int DIV     = 2;
  localparam int STEP    = 'h40;
  localparam bit PREEMPT = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        period_tick;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [15:0] tgt_r, tgt_g, tgt_b;
  logic        fade_en;
  logic [15:0] duty_r, duty_g, duty_b;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int m_cur [3];
  int m_tgt [3];
  bit m_fading;
  bit m_done;
  bit m_tick_prev;
  int m_events;
  int done_count;

  always #5 clk = ~clk;

  rgb_fader #(.W(16), .DIV(DIV), .STEP(STEP), .PREEMPT(PREEMPT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (period_tick),
    .tgt_valid   (tgt_valid),
    .tgt_ready   (tgt_ready),
    .tgt_r       (tgt_r),
    .tgt_g       (tgt_g),
    .tgt_b       (tgt_b),
    .fade_en     (fade_en),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
    m_fading    = 0;
    m_done      = 0;
    m_tick_prev = 0;
    m_events    = 0;
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    int  in_t [3];
    bit  ready, acc, ev, same;
    in_t[0] = int'(tgt_r);
    in_t[1] = int'(tgt_g);
    in_t[2] = int'(tgt_b);
    ready = !m_fading || PREEMPT;
    acc   = tgt_valid && ready;
    ev    = period_tick && !m_tick_prev;
    m_tick_prev = period_tick;
    m_done = 0;
    if (acc) begin
      same = (in_t[0] == m_cur[0]) && (in_t[1] == m_cur[1]) && (in_t[2] == m_cur[2]);
      for (int i = 0; i < 3; i++) m_tgt[i] = in_t[i];
      m_events = 0;
      if (!fade_en || same) begin
        for (int i = 0; i < 3; i++) m_cur[i] = in_t[i];
        m_done   = 1;
        m_fading = 0;
      end else begin
        m_fading = 1;
      end
    end else if (m_fading && ev) begin
      m_events++;
      if (m_events % DIV == 0) begin
        for (int i = 0; i < 3; i++) begin
          int d;
          d = m_tgt[i] - m_cur[i];
          if (d > STEP)       m_cur[i] += STEP;
          else if (d < -STEP) m_cur[i] -= STEP;
          else                m_cur[i] = m_tgt[i];
        end
        if (m_cur[0] == m_tgt[0] && m_cur[1] == m_tgt[1] && m_cur[2] == m_tgt[2]) begin
          m_fading = 0;
          m_done   = 1;
        end
      end
    end
  endtask

  function automatic logic [63:0] expected_vec(input bit in_reset);
    logic [15:0] r, g, b;
    bit rdy;
    r = 16'(m_cur[0]);
    g = 16'(m_cur[1]);
    b = 16'(m_cur[2]);
    rdy = in_reset ? 1'b0 : (!m_fading || PREEMPT);
    return {13'd0, r, g, b, m_fading, m_done, rdy};
  endfunction

  function automatic logic [63:0] observed_vec();
    return {13'd0, duty_r, duty_g, duty_b, busy, done, tgt_ready};
  endfunction

  // One clock: inputs already driven; predict, clock, compare, return at negedge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag, observed_vec(), expected_vec(1'b0));
    if (done) done_count++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tgt_valid   = 1'b0;
    period_tick = 1'b0;
    fade_en     = 1'b0;
  endtask

  task automatic offer(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                       input logic fe, input string tag);
    tgt_r = r; tgt_g = g; tgt_b = b; fade_en = fe; tgt_valid = 1'b1;
    cycle(tag);
    tgt_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_async", observed_vec(), expected_vec(1'b1));
    for (int k = 0; k < 3; k++) begin
      tgt_valid   = 1'($urandom);
      period_tick = 1'($urandom);
      fade_en     = 1'($urandom);
      tgt_r = 16'($urandom); tgt_g = 16'($urandom); tgt_b = 16'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", observed_vec(), expected_vec(1'b1));
      @(negedge clk);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {63'd0, tgt_ready}, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tgt_r = '0; tgt_g = '0; tgt_b = '0;
    done_count = 0;
    model_reset();

    // Reset with random inputs
    do_reset();

    // Jump
    done_count = 0;
    offer(16'h1234, 16'h0000, 16'hFFFF, 1'b0, "jump");
    check("jump_duty", {16'd0, duty_r, duty_g, duty_b}, {16'd0, 16'h1234, 16'h0000, 16'hFFFF});
    cycle("jump_after");
    cycle("jump_after");
    check("jump_done_count", 64'(done_count), 64'd1);

    // Fade from 0 to (0x100,0x50,0), tick every 10 clk
    do_reset();
    done_count = 0;
    offer(16'h0100, 16'h0050, 16'h0000, 1'b1, "fade_start");
    check("fade_busy", {63'd0, busy}, 64'd1);
    for (int c = 0; c < 85; c++) begin
      period_tick = (c % 10 == 0);
      cycle("fade");
    end
    check("fade_final", {16'd0, duty_r, duty_g, duty_b}, {16'd0, 16'h0100, 16'h0050, 16'h0000});
    check("fade_done_count", 64'(done_count), 64'd1);

    // Downward clamp: 0x100 -> 0xF0 in one step
    done_count = 0;
    offer(16'h00F0, 16'h0050, 16'h0000, 1'b1, "clamp_start");
    for (int c = 0; c < 8; c++) begin
      period_tick = (c % 4 == 0);
      cycle("clamp");
    end
    check("clamp_final", 64'(duty_r), 64'h00F0);
    check("clamp_done_count", 64'(done_count), 64'd1);

    // Preempt collision: accept on the tick that would step
    do_reset();
    offer(16'h0200, 16'h0000, 16'h0000, 1'b1, "coll_start");
    period_tick = 1'b1; cycle("coll_ev1");
    period_tick = 1'b0; cycle("coll_gap");
    period_tick = 1'b1;
    offer(16'h0080, 16'h0010, 16'h0000, 1'b1, "coll_accept");
    check("coll_no_step", 64'(duty_r), 64'h0000);
    for (int c = 0; c < 12; c++) begin
      period_tick = (c % 3 == 1);
      cycle("coll_resume");
    end
    check("coll_resumed", 64'(duty_r), 64'h0080);

    // Tick held high for 5 clk counts once
    do_reset();
    offer(16'h0100, 16'h0000, 16'h0000, 1'b1, "held_start");
    for (int c = 0; c < 5; c++) begin
      period_tick = 1'b1;
      cycle("held_high");
    end
    period_tick = 1'b0; cycle("held_low");
    check("held_no_step", 64'(duty_r), 64'h0000);
    period_tick = 1'b1; cycle("held_ev2");
    period_tick = 1'b0; cycle("held_low2");
    check("held_step", 64'(duty_r), 64'h0040);

    // Async reset mid-fade
    period_tick = 1'b1; cycle("mid_a");
    period_tick = 1'b0; cycle("mid_b");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_reset", observed_vec(), expected_vec(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_after", observed_vec(), expected_vec(1'b0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tgt_valid   = ($urandom_range(0, 15) == 0);
      fade_en     = ($urandom_range(0, 3) != 0);
      period_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        tgt_r = 16'(m_cur[0]); tgt_g = 16'(m_cur[1]); tgt_b = 16'(m_cur[2]);
      end else if ($urandom_range(0, 7) == 0) begin
        tgt_r = 16'($urandom); tgt_g = 16'($urandom); tgt_b = 16'($urandom);
      end else begin
        tgt_r = 16'($urandom_range(0, 'h1FF));
        tgt_g = 16'($urandom_range(0, 'h1FF));
        tgt_b = 16'($urandom_range(0, 'h1FF));
      end
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
